// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: turns deserialized words into register-file writes and readback bytes.
// Latency: writes and tx loads are registered on the edge that completes the word (1 spi_clk).
// Backpressure: none; the SPI master paces every transfer, so the decoder never stalls.
module spi_cmd_decoder #(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                  spi_clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  pico,
  input  logic [7:0]            byte_deser,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic [7:0]            tx_byte,
  output logic                  tx_load,
  output logic                  frame_err
);

  typedef enum logic [1:0] {
    ST_CMD   = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  localparam logic [7:0] NREGS8 = 8'(NUM_REGS);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] ptr;
  logic [7:0] word_dat;
  logic       ptr_in_range;
  logic       deser_msb_unused;

  // The oldest deserializer bit has already left the byte window on the completing edge.
  assign deser_msb_unused = byte_deser[7];

  // The completed word is the seven older bits plus the bit arriving on this edge.
  assign word_dat     = {byte_deser[6:0], pico};
  assign ptr_in_range = ({1'b0, ptr} < NREGS8);

  // Register readback; addresses past the end of the file read as zero.
  function automatic logic [7:0] rd_reg(input logic [6:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (a == 7'(k)) r = regs[8*k +: 8];
    end
    return r;
  endfunction

  // Frame FSM, bit counter, register file and all registered outputs.
  always_ff @(posedge spi_clk) begin
    if (rst) begin
      regs      <= {NUM_REGS{RESET_VAL}};
      state     <= ST_CMD;
      bit_cnt   <= 3'd0;
      ptr       <= 7'd0;
      wr_strobe <= 1'b0;
      wr_addr   <= 7'd0;
      tx_byte   <= 8'h00;
      tx_load   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      tx_load   <= 1'b0;
      if (!cs) begin
        // Frame end: resynchronise, and flag a frame that stopped mid-word.
        state   <= ST_CMD;
        bit_cnt <= 3'd0;
        if (bit_cnt != 3'd0) frame_err <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          case (state)
            ST_CMD: begin
              frame_err <= 1'b0;
              ptr       <= word_dat[6:0];
              if (word_dat[7]) begin
                state   <= ST_READ;
                tx_load <= 1'b1;
                tx_byte <= rd_reg(word_dat[6:0]);
              end else begin
                state <= ST_WRITE;
              end
            end
            ST_WRITE: begin
              // Out-of-range words are dropped but still advance the pointer.
              if (ptr_in_range) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                  if (ptr == 7'(k)) regs[8*k +: 8] <= word_dat;
                end
                wr_strobe <= 1'b1;
                wr_addr   <= ptr;
              end
              ptr <= ptr + 7'd1;
            end
            ST_READ: begin
              // Incoming word is dummy data; present the next register.
              ptr     <= ptr + 7'd1;
              tx_load <= 1'b1;
              tx_byte <= rd_reg(ptr + 7'd1);
            end
            default: state <= ST_CMD;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Randomized scoreboard bench for spi_cmd_decoder with a frame-level reference model.
// Latency: expected writes/loads are queued per frame and matched whenever the DUT pulses them.
// Backpressure: none; the bench drives bits at a fixed rate.
module tb_spi_cmd_decoder;
  localparam int NR = 16;

  logic            spi_clk;
  logic            rst;
  logic            cs;
  logic            pico;
  logic [7:0]      byte_deser;
  logic [NR*8-1:0] regs;
  logic            wr_strobe;
  logic [6:0]      wr_addr;
  logic [7:0]      tx_byte;
  logic            tx_load;
  logic            frame_err;

  spi_cmd_decoder #(.NUM_REGS(NR), .RESET_VAL(8'h00)) dut (
    .spi_clk    (spi_clk),
    .rst        (rst),
    .cs         (cs),
    .pico       (pico),
    .byte_deser (byte_deser),
    .regs       (regs),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .tx_byte    (tx_byte),
    .tx_load    (tx_load),
    .frame_err  (frame_err)
  );

  initial spi_clk = 1'b0;
  always #5 spi_clk = ~spi_clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  sh;
  logic [7:0]  mdl [128];
  logic        mdl_err;
  logic [14:0] exp_wr [$];
  logic [7:0]  exp_tx [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pop expected events whenever the DUT pulses a write or a tx load.
  always @(negedge spi_clk) begin
    if (wr_strobe) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_wr_strobe", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        logic [14:0] e;
        e = exp_wr.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[14:8]));
        chk("wr_data", 32'(regs[8*wr_addr +: 8]), 32'(e[7:0]));
      end
    end
    if (tx_load) begin
      if (exp_tx.size() == 0) begin
        chk("unexpected_tx_load", 32'(tx_byte), 32'hFFFF_FFFF);
      end else begin
        chk("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
      end
    end
  end

  task automatic send_bit(input logic v);
    @(negedge spi_clk);
    cs = 1'b1; pico = v; byte_deser = sh;
    @(posedge spi_clk);
    sh = {sh[6:0], v};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge spi_clk);
      cs = 1'b0; pico = 1'($urandom); byte_deser = sh;
      @(posedge spi_clk);
    end
  endtask

  // Frame-level model: command byte selects mode and base address, data bytes follow in order.
  task automatic model_frame(input logic [31:0] bp, input int n, input int tail);
    logic [7:0] cmd;
    int         ad;
    if (n >= 1) begin
      cmd = bp[7:0];
      mdl_err = 1'b0;
      if (cmd[7]) begin
        for (int j = 0; j < n; j++) begin
          ad = (int'(cmd[6:0]) + j) % 128;
          exp_tx.push_back(ad < NR ? mdl[ad] : 8'h00);
        end
      end else begin
        for (int j = 1; j < n; j++) begin
          ad = (int'(cmd[6:0]) + j - 1) % 128;
          if (ad < NR) begin
            mdl[ad] = bp[8*j +: 8];
            exp_wr.push_back({7'(ad), bp[8*j +: 8]});
          end
        end
      end
    end
    if (tail > 0) mdl_err = 1'b1;
  endtask

  task automatic frame(input logic [31:0] bp, input int n, input int tail,
                       input logic [7:0] tbits, input int gap);
    model_frame(bp, n, tail);
    for (int j = 0; j < n; j++)
      for (int i = 7; i >= 0; i--) send_bit(bp[8*j + i]);
    for (int i = 0; i < tail; i++) send_bit(tbits[7 - i]);
    idle(gap);
    @(negedge spi_clk);
    chk("frame_err", 32'(frame_err), 32'(mdl_err));
  endtask

  task automatic chk_regs(input string nm);
    for (int k = 0; k < NR; k++) chk(nm, 32'(regs[8*k +: 8]), 32'(mdl[k]));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 128; k++) mdl[k] = 8'h00;
    mdl_err = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp;
    int          n;
    int          tail;
    logic [7:0]  cmd;

    rst = 1'b1; cs = 1'b0; pico = 1'b0; byte_deser = 8'h00; sh = 8'h00;
    model_reset();
    repeat (2) @(posedge spi_clk);
    @(negedge spi_clk);
    chk("rst_wr_strobe", 32'(wr_strobe), 0);
    chk("rst_wr_addr",   32'(wr_addr), 0);
    chk("rst_tx_byte",   32'(tx_byte), 0);
    chk("rst_tx_load",   32'(tx_load), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk_regs("rst_regs");
    rst = 1'b0;
    idle(1);

    // Write burst at 3, then preload 7/8 and read them back.
    frame({8'h00, 8'h5A, 8'hA5, 8'h03}, 3, 0, 8'h00, 1);
    chk_regs("burst_regs");
    frame({8'h00, 8'hC3, 8'h3C, 8'h07}, 3, 0, 8'h00, 1);
    frame({16'h0000, 8'h00, 8'h87}, 2, 0, 8'h00, 1);

    // Boundary, wrap, and out-of-range read.
    frame({8'h00, 8'h22, 8'h11, 8'h0F}, 3, 0, 8'h00, 1);
    frame({8'h00, 8'h55, 8'h44, 8'h7F}, 3, 0, 8'h00, 1);
    frame({16'h0000, 8'h00, 8'h90}, 2, 0, 8'h00, 1);
    chk_regs("boundary_regs");

    // Aborted frame then a clean rewrite.
    frame({24'h0, 8'h02}, 1, 5, 8'hF8, 1);
    frame({16'h0, 8'h99, 8'h02}, 2, 0, 8'h00, 1);
    chk_regs("abort_regs");

    // Reset asserted on the 4th bit of a data byte.
    for (int i = 7; i >= 0; i--) send_bit(i == 1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge spi_clk);
    rst = 1'b1; cs = 1'b1; pico = 1'b1; byte_deser = sh;
    @(posedge spi_clk);
    sh = {sh[6:0], 1'b1};
    @(negedge spi_clk);
    rst = 1'b0;
    model_reset();
    chk("midrst_frame_err", 32'(frame_err), 0);
    chk_regs("midrst_regs");
    idle(1);
    frame({16'h0, 8'h6B, 8'h05}, 2, 0, 8'h00, 1);

    // Back-to-back frames with a single idle edge.
    frame({16'h0, 8'hE1, 8'h0A}, 2, 0, 8'h00, 1);
    frame({16'h0, 8'h1E, 8'h0B}, 2, 0, 8'h00, 1);
    chk_regs("b2b_regs");

    // Randomized frames.
    for (int f = 0; f < 60; f++) begin
      cmd = 8'($urandom);
      if ($urandom_range(0, 2) != 0) cmd[6:0] = 7'($urandom_range(0, 19));
      else if ($urandom_range(0, 1) == 0) cmd[6:0] = 7'($urandom_range(120, 127));
      bp = $urandom;
      bp[7:0] = cmd;
      n = $urandom_range(0, 4);
      tail = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      if (n == 0 && tail == 0) n = 1;
      frame(bp, n, tail, 8'($urandom), $urandom_range(1, 3));
    end

    idle(2);
    @(negedge spi_clk);
    chk_regs("final_regs");
    chk("exp_wr_left", 32'(exp_wr.size()), 0);
    chk("exp_tx_left", 32'(exp_tx.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
